// File: rtl/irq_sched.sv
// irq_sched -- four-source interrupt scheduler for a small MIPS-style CPU.
//
// REQ lines are level inputs that are sampled and edge-detected. Each 0->1
// transition latches a PEND bit. A pending, unmasked source is granted by
// raising IRQ, capturing CAUSE/EPC and dropping RUN, which freezes the CPU
// clock divider. The CPU answers with an IACK handshake. If IACK never
// arrives within TMO cycles, the grant is abandoned and TOUT is set.
//
// Ports:
//   CLK, RST     clock, asynchronous active-high reset
//   REQ[3:0]     request levels (0 keyboard, 1 syscall, 2 timer, 3 spare)
//   PC           current program counter, captured into EPC at grant
//   IACK         CPU acknowledge
//   MASK_WE/IN   mask write strobe and value (1 = source disabled)
//   IRQ          interrupt to the CPU
//   CAUSE        id of the source being serviced
//   EPC          PC captured at grant
//   RUN          CPU clock enable (0 while servicing)
//   PEND         pending bits
//   TOUT         sticky timeout flag; cleared by reset or a mask write of 4'hF
//
// Build option: define IRQ_SCHED_RR_EN for round-robin selection. Without it,
// selection is fixed priority and the lowest index wins.
module irq_sched #(
  parameter int EPC_W = 17,
  parameter int TMO   = 255
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [3:0]       REQ,
  input  logic [EPC_W-1:0] PC,
  input  logic             IACK,
  input  logic             MASK_WE,
  input  logic [3:0]       MASK_IN,
  output logic             IRQ,
  output logic [1:0]       CAUSE,
  output logic [EPC_W-1:0] EPC,
  output logic             RUN,
  output logic [3:0]       PEND,
  output logic             TOUT
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ASSERT = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [3:0]       req_q, req_d;       // newest REQ sample
  logic [3:0]       req_h_q, req_h_d;   // previous REQ sample
  logic             init_q, init_d;     // low until the first edge after reset
  logic [3:0]       pend_q, pend_d;
  logic [3:0]       mask_q, mask_d;
  logic [1:0]       cause_q, cause_d;
  logic [EPC_W-1:0] epc_q, epc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             tout_q, tout_d;
  logic [3:0]       rise, clr, elig;
  logic [1:0]       sel;

  assign elig = pend_q & ~mask_q;
  // The edge is taken between two registered samples, so a rise sampled at
  // edge n sets PEND at edge n+1.
  assign rise = req_q & ~req_h_q;

`ifdef IRQ_SCHED_RR_EN
  logic [1:0] rr_q, rr_d;
  logic [1:0] idx;

  // Search from rr_q+1 upward. The last match assigned wins, so scan from
  // the farthest slot down to the nearest.
  always_comb begin
    sel = 2'd0;
    idx = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      idx = rr_q + 2'(k);
      if (elig[idx]) sel = idx;
    end
  end
`else
  always_comb begin
    sel = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (elig[i]) sel = 2'(i);
  end
`endif

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    epc_d   = epc_q;
    cnt_d   = cnt_q;
    tout_d  = tout_q;
    mask_d  = mask_q;
    clr     = '0;
`ifdef IRQ_SCHED_RR_EN
    rr_d    = rr_q;
`endif
    // The first edge after reset only primes the history, so a line that is
    // already high is not mistaken for a new edge.
    init_d  = 1'b1;
    req_d   = REQ;
    req_h_d = init_q ? req_q : REQ;

    if (MASK_WE) begin
      mask_d = MASK_IN;
      if (MASK_IN == 4'hF) tout_d = 1'b0;
    end

    case (state_q)
      S_IDLE: if (|elig) begin
        state_d = S_ASSERT;
        cause_d = sel;
        epc_d   = PC;
        cnt_d   = 8'd0;
`ifdef IRQ_SCHED_RR_EN
        rr_d    = sel;
`endif
      end
      S_ASSERT: begin
        if (IACK) begin
          clr[cause_q] = 1'b1;
          state_d      = S_DRAIN;
        end else if (cnt_q == 8'(TMO)) begin
          // The abort leaves PEND set, so the source is granted again from IDLE.
          tout_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DRAIN: if (!IACK) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A new edge on the source being cleared in this cycle keeps PEND set.
    pend_d = (pend_q & ~clr) | rise;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      req_h_q <= '0;
      init_q  <= 1'b0;
      pend_q  <= '0;
      mask_q  <= '0;
      cause_q <= '0;
      epc_q   <= '0;
      cnt_q   <= '0;
      tout_q  <= 1'b0;
`ifdef IRQ_SCHED_RR_EN
      rr_q    <= 2'd3;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      req_h_q <= req_h_d;
      init_q  <= init_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
      cnt_q   <= cnt_d;
      tout_q  <= tout_d;
`ifdef IRQ_SCHED_RR_EN
      rr_q    <= rr_d;
`endif
    end
  end

  assign IRQ   = (state_q == S_ASSERT);
  assign RUN   = (state_q == S_IDLE);
  assign CAUSE = cause_q;
  assign EPC   = epc_q;
  assign PEND  = pend_q;
  assign TOUT  = tout_q;

endmodule
